// File: rtl/io_bus_master.sv
// io_bus_master: initiator for the 4-bit-addressed IO port bus.
// This block takes one read or write from the core and drives it onto the
// IO port bank. It then returns a buffered response, with an error flag
// for unmapped addresses. Only one transaction is outstanding at a time.
module io_bus_master #(
   parameter int BITS        = 16,
   parameter int NUM_PORTS   = 4,   // mapped addresses 0..NUM_PORTS-1, 1..16
   parameter int WAIT_CYCLES = 1    // extra strobe cycles beyond the first, 0..15
) (
   input  logic            clk,
   input  logic            rst,
   // core request channel
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [3:0]      req_addr,
   input  logic [BITS-1:0] req_wdata,
   // core response channel
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [BITS-1:0] rsp_rdata,
   output logic            rsp_err,
   // peripheral bus
   output logic            io_en,
   output logic            io_r_or_w,
   output logic [3:0]      io_addr,
   output logic [BITS-1:0] io_wdata,
   input  logic [BITS-1:0] io_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
   localparam logic [4:0] PORT_LIMIT = 5'(NUM_PORTS);

   logic [1:0] state;
   logic [3:0] wait_cnt;
   logic       addr_mapped;

   // Decode whether the incoming address lands on an existing port.
   // The extra MSB lets NUM_PORTS=16 compare correctly.
   assign addr_mapped = ({1'b0, req_addr} < PORT_LIMIT);

   // Sequencer: every output is a register that is updated on state transitions.
   // The io_* registers also serve as the latched copy of the request.
   // They keep their last driven value while idle.
   // NOTE: sequential state uses non-blocking assignments only, and the
   // synchronous reset sits inside the clocked block, so it acts on an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         io_en     <= 1'b0;
         io_r_or_w <= 1'b0;
         io_addr   <= '0;
         io_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (addr_mapped) begin
                     io_addr   <= req_addr;
                     io_wdata  <= req_wdata;
                     io_r_or_w <= req_write;
                     rsp_err   <= 1'b0;
                     state     <= SETUP;
                  end else begin
                     // Unmapped address: respond at once and leave the bus untouched.
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end

            SETUP: begin
               wait_cnt <= WAIT_INIT;
               io_en    <= 1'b1;
               state    <= STROBE;
            end

            STROBE: begin
               if (wait_cnt == 4'd0) begin
                  // Last strobe cycle: a read samples the peripheral, a write returns 0.
                  rsp_rdata <= io_r_or_w ? '0 : io_rdata;
                  io_en     <= 1'b0;
                  io_r_or_w <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               io_en     <= 1'b0;
               io_r_or_w <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_master.sv
// Testbench for io_bus_master. Random transactions are checked against a
// timeline model: accept at k=0, SETUP at k=1, strobe at k=2..2+WAIT_CYCLES,
// and the response from k=3+WAIT_CYCLES. An unmapped address responds at k=1.
module tb_io_bus_master;

   localparam int BITS        = 16;
   localparam int NUM_PORTS   = 4;
   localparam int WAIT_CYCLES = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [3:0]      req_addr;
   logic [BITS-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [BITS-1:0] rsp_rdata;
   logic            rsp_err;
   logic            io_en;
   logic            io_r_or_w;
   logic [3:0]      io_addr;
   logic [BITS-1:0] io_wdata;
   wire  [BITS-1:0] io_rdata;
   logic [BITS-1:0] periph_val;

   int n_cmp = 0;
   int n_bad = 0;

   // Peripheral model: drives data only while the bus is enabled.
   assign io_rdata = io_en ? periph_val : 'z;

   always #5 clk = ~clk;

   io_bus_master #(
      .BITS(BITS), .NUM_PORTS(NUM_PORTS), .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .io_en(io_en), .io_r_or_w(io_r_or_w), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata)
   );

   // Runs one transaction starting at a negedge in IDLE, checking every cycle.
   // hold   : number of RESP cycles with rsp_ready low before the handshake
   // junk   : keep req_valid high with other fields while busy (must be ignored)
   task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [BITS-1:0] wd,
                          input int hold, input bit junk, input string tag);
      bit              mapped;
      bit              exp_en;
      bit              exp_rv;
      int              first;
      int              last_k;
      logic [BITS-1:0] last_pv;
      logic [BITS-1:0] exp_rd;
      mapped  = (int'(addr) < NUM_PORTS);
      first   = mapped ? 3 + WAIT_CYCLES : 1;
      last_k  = first + hold;
      last_pv = '0;
      exp_rd  = '0;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s accept_ready: got %b want 1", tag, req_ready);
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      rsp_ready = (hold == 0);
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clk);
         req_valid = junk && (k != last_k);
         if (junk) begin
            req_addr  = ~addr;
            req_write = ~wr;
            req_wdata = ~wd;
         end
         exp_en = mapped && (k >= 2) && (k <= 2 + WAIT_CYCLES);
         exp_rv = (k >= first);
         if (k == first) exp_rd = (mapped && !wr) ? last_pv : '0;
         n_cmp++;
         if (io_en !== exp_en) begin
            n_bad++;
            $display("FAIL %s io_en k=%0d: got %b want %b", tag, k, io_en, exp_en);
         end
         n_cmp++;
         if (rsp_valid !== exp_rv) begin
            n_bad++;
            $display("FAIL %s rsp_valid k=%0d: got %b want %b", tag, k, rsp_valid, exp_rv);
         end
         n_cmp++;
         if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s req_ready_busy k=%0d: got %b want 0", tag, k, req_ready);
         end
         if (mapped && !exp_rv) begin
            n_cmp++;
            if (io_addr !== addr || io_r_or_w !== wr || io_wdata !== wd) begin
               n_bad++;
               $display("FAIL %s bus k=%0d: got a=%0d w=%b d=%h want a=%0d w=%b d=%h",
                        tag, k, io_addr, io_r_or_w, io_wdata, addr, wr, wd);
            end
         end
         if (exp_rv) begin
            n_cmp++;
            if (rsp_rdata !== exp_rd || rsp_err !== !mapped || io_r_or_w !== 1'b0) begin
               n_bad++;
               $display("FAIL %s resp k=%0d: got rd=%h err=%b rw=%b want rd=%h err=%b rw=0",
                        tag, k, rsp_rdata, rsp_err, io_r_or_w, exp_rd, !mapped);
            end
            if (k - first == hold) rsp_ready = 1'b1;
         end
         if (exp_en) begin
            periph_val = BITS'($urandom);
            last_pv    = periph_val;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || io_en !== 1'b0) begin
         n_bad++;
         $display("FAIL %s after_handshake: got ready=%b valid=%b en=%b want 1 0 0",
                  tag, req_ready, rsp_valid, io_en);
      end
      if (mapped) begin
         n_cmp++;
         if (io_addr !== addr || io_wdata !== wd) begin
            n_bad++;
            $display("FAIL %s hold_bus: got a=%0d d=%h want a=%0d d=%h", tag, io_addr, io_wdata, addr, wd);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         n_cmp++;
         if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0 ||
             io_en !== 1'b0 || io_r_or_w !== 1'b0 || io_addr !== 4'd0 || io_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_values cyc=%0d: got rdy=%b v=%b e=%b rd=%h en=%b rw=%b a=%h d=%h want 1 0 0 0 0 0 0 0",
                     i, req_ready, rsp_valid, rsp_err, rsp_rdata, io_en, io_r_or_w, io_addr, io_wdata);
         end
      end
   endtask

   task automatic test_write();
      run_txn(1'b1, 4'd2, 16'h0001, 0, 1'b0, "write_a2");
   endtask

   task automatic test_read();
      run_txn(1'b0, 4'd1, 16'h0000, 0, 1'b0, "read_a1");
   endtask

   task automatic test_error();
      run_txn(1'b0, 4'd7, 16'h1234, 0, 1'b0, "err_a7");
      run_txn(1'b1, 4'd15, 16'hbeef, 1, 1'b1, "err_a15");
   endtask

   task automatic test_backpressure();
      run_txn(1'b0, 4'd3, BITS'($urandom), 5, 1'b1, "bp_read");
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 4'd0, BITS'($urandom), 0, 1'b0, "b2b_0");
      run_txn(1'b0, 4'd0, BITS'($urandom), 0, 1'b0, "b2b_1");
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'd3;
      req_wdata = 16'ha5a5;
      rsp_ready = 1'b1;
      @(negedge clk);                 // SETUP
      req_valid = 1'b0;
      @(negedge clk);                 // first strobe cycle
      n_cmp++;
      if (io_en !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid strobe: got io_en=%b want 1", io_en);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (io_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || io_r_or_w !== 1'b0 ||
          io_addr !== 4'd0 || io_wdata !== '0) begin
         n_bad++;
         $display("FAIL rst_mid after: got en=%b v=%b rdy=%b rw=%b a=%h d=%h want 0 0 1 0 0 0",
                  io_en, rsp_valid, req_ready, io_r_or_w, io_addr, io_wdata);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b0 || io_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid quiet cyc=%0d: got v=%b en=%b want 0 0", i, rsp_valid, io_en);
         end
      end
      rsp_ready = 1'b0;
      run_txn(1'b1, 4'd3, 16'h5a5a, 0, 1'b0, "rst_mid_next");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_txn(1'($urandom), 4'($urandom), BITS'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      periph_val = '0;
      test_reset();
      test_write();
      test_read();
      test_error();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
